// File: rtl/puf_ctrl_pkg.sv
// Shared types, defaults and LFSR helper for the PUF challenge sequencer.
// The LFSR is fixed at 8 bits; wider challenges zero-extend it.
package puf_ctrl_pkg;

  localparam int DEF_CHAL_W = 8;
  localparam int DEF_RESP_W = 7;
  localparam int DEF_VOTES  = 5;
  localparam int DEF_SETTLE = 2;

  localparam logic [7:0] LFSR_MASK = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FIRE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_OUT    = 3'd5,
    ST_NEXT   = 3'd6
  } puf_state_t;

  // Galois form, right shift: the mask folds in only when a 1 falls off the lsb.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    logic [7:0] nxt;
    nxt = {1'b0, cur[7:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_MASK;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Valid/ready stream carrying one majority-voted response and the challenge
// that produced it.
interface puf_challenge_sequencer_if
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W = DEF_CHAL_W,
  parameter int RESP_W = DEF_RESP_W
);

  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] resp_data;
  logic [CHAL_W-1:0] resp_challenge;

  modport master (
    output resp_valid,
    output resp_data,
    output resp_challenge,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_data,
    input  resp_challenge,
    output resp_ready
  );

endinterface

// File: rtl/puf_vote_acc.sv
// Per-bit vote counters for the PUF response and the majority decision.
// A bit is reported as 1 when strictly more than half of the votes were 1.
module puf_vote_acc
  import puf_ctrl_pkg::*;
#(
  parameter int RESP_W = DEF_RESP_W,
  parameter int VOTES  = DEF_VOTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [RESP_W-1:0] bits_in,
  output logic [RESP_W-1:0] majority
);

  localparam int CNT_W = $clog2(VOTES + 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(VOTES / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < RESP_W; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (sample && bits_in[gi]) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
      end

      assign majority[gi] = (cnt_reg > HALF);
    end
  endgenerate

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives challenges into an arbiter PUF, launches VOTES times per challenge,
// majority-votes the responses and streams them out; challenges step via LFSR.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int CHAL_W = DEF_CHAL_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int VOTES  = DEF_VOTES,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHAL_W-1:0]         seed,
  input  logic [7:0]                count,
  output logic                      busy,
  output logic [CHAL_W-1:0]         puf_challenge,
  output logic                      puf_launch,
  input  logic [RESP_W-1:0]         puf_response,
  puf_challenge_sequencer_if.master resp_if,
  output logic                      done
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] VOTES_LAST  = 4'(VOTES - 1);

  puf_state_t        state_reg, state_next;
  logic [3:0]        timer_reg, timer_next;
  logic [3:0]        vote_reg, vote_next;
  logic [7:0]        remain_reg, remain_next;
  logic [CHAL_W-1:0] chal_reg, chal_next;
  logic              busy_reg, busy_next;
  logic              launch_reg, launch_next;
  logic              done_reg, done_next;
  logic              valid_reg, valid_next;
  logic [RESP_W-1:0] rdata_reg, rdata_next;
  logic [CHAL_W-1:0] rchal_reg, rchal_next;

  logic              vote_clear;
  logic              vote_sample;
  logic [RESP_W-1:0] vote_majority;

  puf_vote_acc #(
    .RESP_W (RESP_W),
    .VOTES  (VOTES)
  ) u_vote_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (vote_clear),
    .sample   (vote_sample),
    .bits_in  (puf_response),
    .majority (vote_majority)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      vote_reg   <= '0;
      remain_reg <= '0;
      chal_reg   <= '0;
      busy_reg   <= 1'b0;
      launch_reg <= 1'b0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      rdata_reg  <= '0;
      rchal_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      vote_reg   <= vote_next;
      remain_reg <= remain_next;
      chal_reg   <= chal_next;
      busy_reg   <= busy_next;
      launch_reg <= launch_next;
      done_reg   <= done_next;
      valid_reg  <= valid_next;
      rdata_reg  <= rdata_next;
      rchal_reg  <= rchal_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    vote_next   = vote_reg;
    remain_next = remain_reg;
    chal_next   = chal_reg;
    valid_next  = valid_reg;
    rdata_next  = rdata_reg;
    rchal_next  = rchal_reg;
    done_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The cycle showing done is the tail of the previous run, so a
        // start arriving alongside it is dropped.
        if (start && !done_reg) begin
          if (count == 8'd0) begin
            done_next = 1'b1;
          end else begin
            state_next  = ST_LOAD;
            remain_next = count;
            timer_next  = '0;
            vote_next   = '0;
            chal_next   = (seed == '0) ? CHAL_W'(1) : seed;
          end
        end
      end

      ST_LOAD: begin
        if (timer_reg == SETTLE_LAST) begin
          timer_next = '0;
          state_next = ST_FIRE;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      ST_FIRE: begin
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        if (timer_reg == SETTLE_LAST) begin
          timer_next = '0;
          state_next = ST_SAMPLE;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (vote_reg == VOTES_LAST) begin
          vote_next  = '0;
          state_next = ST_OUT;
        end else begin
          vote_next  = vote_reg + 4'd1;
          state_next = ST_LOAD;
        end
      end

      // First OUT cycle latches the vote (counters settle on SAMPLE exit);
      // afterwards the registered result is held until it is taken.
      ST_OUT: begin
        if (!valid_reg) begin
          valid_next = 1'b1;
          rdata_next = vote_majority;
          rchal_next = chal_reg;
        end else if (resp_if.resp_ready) begin
          valid_next  = 1'b0;
          remain_next = remain_reg - 8'd1;
          done_next   = (remain_reg == 8'd1);
          state_next  = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (remain_reg != 8'd0) begin
          chal_next  = CHAL_W'(lfsr_step(8'(chal_reg)));
          timer_next = '0;
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign launch_next = (state_next == ST_FIRE);
  assign busy_next   = (state_next != ST_IDLE);

  assign vote_clear  = (state_next == ST_LOAD) &&
                       ((state_reg == ST_IDLE) || (state_reg == ST_NEXT));
  assign vote_sample = (state_reg == ST_SAMPLE);

  assign busy                   = busy_reg;
  assign puf_challenge          = chal_reg;
  assign puf_launch             = launch_reg;
  assign done                   = done_reg;
  assign resp_if.resp_valid     = valid_reg;
  assign resp_if.resp_data      = rdata_reg;
  assign resp_if.resp_challenge = rchal_reg;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: directed runs push expected responses, a monitor pops
// and compares them on every resp_valid/resp_ready handshake.
module tb_puf_challenge_sequencer;
  import puf_ctrl_pkg::*;

  typedef struct packed {
    logic [6:0] data;
    logic [7:0] chal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] count = '0;
  logic       busy;
  logic [7:0] puf_challenge;
  logic       puf_launch;
  logic [6:0] puf_response = '0;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int launch_cnt = 0;
  int done_cnt   = 0;
  int valid_cnt  = 0;

  logic       use_table = 1'b0;
  int         tbl_base  = 0;
  logic [6:0] resp_const = '0;
  logic [6:0] vote_tbl [5] = '{7'h71, 7'h53, 7'h60, 7'h42, 7'h61};

  exp_t sb_q[$];

  puf_challenge_sequencer_if #(.CHAL_W(8), .RESP_W(7)) rif ();

  puf_challenge_sequencer #(
    .CHAL_W (8),
    .RESP_W (7),
    .VOTES  (5),
    .SETTLE (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .seed          (seed),
    .count         (count),
    .busy          (busy),
    .puf_challenge (puf_challenge),
    .puf_launch    (puf_launch),
    .puf_response  (puf_response),
    .resp_if       (rif),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] s, input logic [7:0] c);
    @(negedge clk);
    seed  = s;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!rif.resp_valid && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!rif.resp_valid) check("wait_valid_timeout", 32'(rif.resp_valid), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int cyc;
    cyc = 0;
    while (!done && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!done) check("wait_done_timeout", 32'(done), 32'd1);
  endtask

  // PUF model plus event counters; the only process driving puf_response.
  initial begin
    forever begin
      @(negedge clk);
      if (puf_launch) begin
        if (use_table) puf_response = vote_tbl[(launch_cnt - tbl_base) % 5];
        launch_cnt++;
      end
      if (!use_table) puf_response = resp_const;
      if (done) done_cnt++;
      if (rif.resp_valid) valid_cnt++;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rif.resp_valid && rif.resp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_resp", 32'(rif.resp_challenge), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] resp data=%02h chal=%02h exp data=%02h chal=%02h",
                   rif.resp_data, rif.resp_challenge, e.data, e.chal);
          check("resp_data", 32'(rif.resp_data), 32'(e.data));
          check("resp_challenge", 32'(rif.resp_challenge), 32'(e.chal));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lbase, dbase, vbase, n;

    rif.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_launch", 32'(puf_launch), 32'd0);
    check("rst_valid", 32'(rif.resp_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_challenge", 32'(puf_challenge), 32'd0);
    check("rst_resp_data", 32'(rif.resp_data), 32'd0);
    check("rst_resp_chal", 32'(rif.resp_challenge), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single challenge, constant response: latency and done timing.
    resp_const = 7'h2B;
    sb_q.push_back('{data: 7'h2B, chal: 8'h5A});
    lbase = launch_cnt;
    start_run(8'h5A, 8'd1);
    $display("[TB] run seed=5a count=1");
    check("busy_after_start", 32'(busy), 32'd1);
    check("challenge_loaded", 32'(puf_challenge), 32'h5A);
    wait_valid(40, cyc);
    check("first_valid_latency", 32'(cyc), 32'd31);
    tick();
    check("done_after_handshake", 32'(done), 32'd1);
    check("valid_dropped", 32'(rif.resp_valid), 32'd0);
    check("busy_with_done", 32'(busy), 32'd1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("launches_run1", 32'(launch_cnt - lbase), 32'd5);

    // Three challenges stepped by the LFSR.
    resp_const = 7'h0F;
    sb_q.push_back('{data: 7'h0F, chal: 8'h01});
    sb_q.push_back('{data: 7'h0F, chal: 8'hB8});
    sb_q.push_back('{data: 7'h0F, chal: 8'h5C});
    lbase = launch_cnt;
    dbase = done_cnt;
    start_run(8'h01, 8'd3);
    $display("[TB] run seed=01 count=3");
    wait_done(200);
    tick();
    check("launches_run3", 32'(launch_cnt - lbase), 32'd15);
    check("done_count_run3", 32'(done_cnt - dbase), 32'd1);

    // Per-vote pattern exercising the majority threshold.
    use_table = 1'b1;
    tbl_base  = launch_cnt;
    sb_q.push_back('{data: 7'h61, chal: 8'h33});
    start_run(8'h33, 8'd1);
    $display("[TB] run seed=33 count=1 vote table");
    wait_done(100);
    tick();
    use_table = 1'b0;

    // Back-pressure: result must hold while resp_ready is low.
    resp_const = 7'h15;
    rif.resp_ready = 1'b0;
    sb_q.push_back('{data: 7'h15, chal: 8'h77});
    start_run(8'h77, 8'd1);
    $display("[TB] run seed=77 count=1 stalled");
    wait_valid(40, cyc);
    lbase = launch_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", 32'(rif.resp_valid), 32'd1);
      check("stall_data", 32'(rif.resp_data), 32'h15);
      check("stall_chal", 32'(rif.resp_challenge), 32'h77);
    end
    check("stall_no_launch", 32'(launch_cnt - lbase), 32'd0);
    rif.resp_ready = 1'b1;
    wait_done(10);
    tick();

    // Zero seed is replaced by 0x01.
    sb_q.push_back('{data: 7'h15, chal: 8'h01});
    start_run(8'h00, 8'd1);
    $display("[TB] run seed=00 count=1");
    check("zero_seed_sub", 32'(puf_challenge), 32'h01);
    wait_done(60);
    tick();

    // Empty run.
    lbase = launch_cnt;
    dbase = done_cnt;
    vbase = valid_cnt;
    start_run(8'h44, 8'd0);
    $display("[TB] run seed=44 count=0");
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_busy_low", 32'(busy), 32'd0);
    end
    check("empty_done_count", 32'(done_cnt - dbase), 32'd1);
    check("empty_no_valid", 32'(valid_cnt - vbase), 32'd0);
    check("empty_no_launch", 32'(launch_cnt - lbase), 32'd0);

    // Start while busy is ignored.
    lbase = launch_cnt;
    dbase = done_cnt;
    sb_q.push_back('{data: 7'h15, chal: 8'h10});
    start_run(8'h10, 8'd1);
    $display("[TB] run seed=10 count=1 with start while busy");
    repeat (8) tick();
    start_run(8'h99, 8'd5);
    check("busy_start_chal", 32'(puf_challenge), 32'h10);
    wait_done(60);
    repeat (40) tick();
    check("busy_start_launches", 32'(launch_cnt - lbase), 32'd5);
    check("busy_start_done", 32'(done_cnt - dbase), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Reset during the third FIRE aborts the run.
    dbase = done_cnt;
    vbase = valid_cnt;
    start_run(8'h22, 8'd2);
    $display("[TB] run seed=22 count=2 reset in third fire");
    n = 0;
    for (int i = 0; i < 100 && n < 3; i++) begin
      tick();
      if (puf_launch) n++;
    end
    check("third_fire_seen", 32'(n), 32'd3);
    rst_n = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_launch", 32'(puf_launch), 32'd0);
    check("abort_valid", 32'(rif.resp_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_challenge", 32'(puf_challenge), 32'd0);
    check("abort_resp_data", 32'(rif.resp_data), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    check("abort_no_valid", 32'(valid_cnt - vbase), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
